// File: rtl/prewish_pkg.sv
// prewish_pkg: shared definitions for the pattern sender slice.
//   PATTERN_W : width of one blink pattern
//   state_e   : sender FSM encodings
package prewish_pkg;

    localparam int unsigned PATTERN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/prewish_fifo.sv
// prewish_fifo: synchronous first-word-fall-through queue.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (flushes pointers/count)
//   push, din     write request and data; accepted when not full or when popping
//   pop, dout     read request; dout always shows the head entry
//   full, empty   registered occupancy flags
module prewish_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/prewish_pattern_sender.sv
// prewish_pattern_sender: queues blink patterns from a local requester and
// delivers them one at a time over a strobe/ack link to a blinky responder.
// Optional feature macro: PREWISH_SENDER_TIMEOUT_EN (ACK wait timeout).
// Ports:
//   CLK_I, RST_I    clock, synchronous active-low reset
//   STB_I, DAT_I    requester load strobe (rising edge pushes DAT_I)
//   FULL_O, DROP_O  queue full, one-cycle pulse when a push is discarded
//   STB_O, DAT_O    transfer strobe and pattern to the responder
//   ACK_I           responder accept
//   BUSY_O          queue non-empty or transfer/gap in progress
//   TMO_O           one-cycle pulse on ACK timeout (tied 0 without the feature)
module prewish_pattern_sender
    import prewish_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_BITS = 2,
    parameter int unsigned GAP_CYCLES      = 4
`ifdef PREWISH_SENDER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_BITS    = 8
`endif
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic [PATTERN_W-1:0] DAT_I,
    output logic                 FULL_O,
    output logic                 DROP_O,
    output logic                 STB_O,
    output logic [PATTERN_W-1:0] DAT_O,
    input  logic                 ACK_I,
    output logic                 BUSY_O,
    output logic                 TMO_O
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_e               state;
    logic                 stb_q;
    logic                 push_c;
    logic                 pop_c;
    logic                 drop_c;
    logic                 tmo_hit_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PATTERN_W-1:0] head;
    logic [GAP_W-1:0]     gap_cnt;

    assign push_c = STB_I & ~stb_q;
    assign pop_c  = (state == ST_SEND) & (ACK_I | tmo_hit_c);
    assign drop_c = push_c & fifo_full & ~pop_c;
    assign FULL_O = fifo_full;
    assign BUSY_O = ~fifo_empty | (state != ST_IDLE);

`ifdef PREWISH_SENDER_TIMEOUT_EN
    // Fires on the (2**TIMEOUT_BITS-1)-th SEND cycle; counter is 0 on the first.
    localparam int unsigned TMO_LAST = (2 ** TIMEOUT_BITS) - 2;

    logic [TIMEOUT_BITS-1:0] wait_cnt;

    assign tmo_hit_c = ~ACK_I & (wait_cnt == TIMEOUT_BITS'(TMO_LAST));
`else
    assign tmo_hit_c = 1'b0;
    assign TMO_O     = 1'b0;
`endif

    prewish_fifo #(
        .W  (PATTERN_W),
        .AW (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .push  (push_c),
        .pop   (pop_c),
        .din   (DAT_I),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Edge detector, transfer FSM, gap counter and optional ACK timeout.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state   <= ST_IDLE;
            stb_q   <= 1'b1;
            STB_O   <= 1'b0;
            DAT_O   <= '0;
            DROP_O  <= 1'b0;
            gap_cnt <= '0;
`ifdef PREWISH_SENDER_TIMEOUT_EN
            TMO_O    <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            stb_q  <= STB_I;
            DROP_O <= drop_c;
`ifdef PREWISH_SENDER_TIMEOUT_EN
            TMO_O  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_SEND;
                        STB_O <= 1'b1;
                        DAT_O <= head;
`ifdef PREWISH_SENDER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (ACK_I) begin
                        state   <= ST_GAP;
                        STB_O   <= 1'b0;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end
`ifdef PREWISH_SENDER_TIMEOUT_EN
                    else if (tmo_hit_c) begin
                        state   <= ST_GAP;
                        STB_O   <= 1'b0;
                        TMO_O   <= 1'b1;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_BITS'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    STB_O <= 1'b0;
                end
            endcase
        end
    end

endmodule
